// File: rtl/ddr3_usr_pkg.sv
// Shared constants, FSM encoding and byte-enable mask helpers for the
// DDR3 user-side write (and read) paths.
package ddr3_usr_pkg;

    localparam int DATA_W      = 256;
    localparam int BE_W        = DATA_W / 8;
    localparam int ADDR_W      = 22;
    localparam int OFF_W       = $clog2(BE_W);
    localparam int BYTE_ADDR_W = ADDR_W + OFF_W;
    localparam int CNT_W       = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Lanes at or above the start offset within the first word.
    function automatic logic [BE_W-1:0] first_mask(input logic [OFF_W-1:0] off);
        return {BE_W{1'b1}} << off;
    endfunction

    // Lanes below the end offset within the last word; an end offset of 0
    // means the transfer ends exactly on a word boundary.
    function automatic logic [BE_W-1:0] last_mask(input logic [OFF_W-1:0] end_off);
        if (end_off == '0)
            return {BE_W{1'b1}};
        return (BE_W'(1) << end_off) - BE_W'(1);
    endfunction

endpackage

// File: rtl/ddr3_be_gen.sv
// Byte-enable generator: combines first-word and last-word lane masks.
// A transfer that fits in one word applies both masks.
module ddr3_be_gen
    import ddr3_usr_pkg::*;
(
    input  logic [OFF_W-1:0] i_first_off,
    input  logic [OFF_W-1:0] i_last_end,
    input  logic             i_is_first,
    input  logic             i_is_last,
    output logic [BE_W-1:0]  o_mask
);

    logic [BE_W-1:0] w_first;
    logic [BE_W-1:0] w_last;

    assign w_first = i_is_first ? first_mask(i_first_off) : {BE_W{1'b1}};
    assign w_last  = i_is_last  ? last_mask(i_last_end)   : {BE_W{1'b1}};
    assign o_mask  = w_first & w_last;

endmodule

// File: rtl/ddr3_usr_write_logic.sv
// DDR3 user write path: turns a byte-range write command plus a stream of
// lane-aligned 256-bit words into single-beat Avalon-MM writes with byte
// enables trimming the unaligned head and tail.
module ddr3_usr_write_logic
    import ddr3_usr_pkg::*;
(
    input  logic                   ddr3_emif_clk,
    input  logic                   ddr3_emif_rst_n,
    input  logic                   ddr3_emif_ready,
    output logic                   ddr3_emif_write,
    output logic                   ddr3_emif_read,
    output logic [ADDR_W-1:0]      ddr3_emif_addr,
    output logic [DATA_W-1:0]      ddr3_emif_write_data,
    output logic [BE_W-1:0]        ddr3_emif_byte_enable,
    output logic [4:0]             ddr3_emif_burst_count,
    input  logic [BYTE_ADDR_W-1:0] ddr3_usr_start_addr_in,
    input  logic [31:0]            to_write_byte_in,
    input  logic                   ddr3_write_start,
    output logic                   ddr3_write_busy_out,
    output logic                   ddr3_write_done_out,
    input  logic [DATA_W-1:0]      write_data_in,
    input  logic                   write_data_valid_in,
    output logic                   write_data_ready_out
);

    state_t            r_state;
    logic [OFF_W-1:0]  r_off;
    logic [OFF_W-1:0]  r_end;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_words;
    logic [CNT_W-1:0]  r_taken;
    logic              r_busy;
    logic              r_done;

    logic              r_wr;
    logic              r_wr_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [BE_W-1:0]   r_be;

    logic [32:0]       w_span;
    logic [CNT_W-1:0]  w_words;
    logic              w_slot;
    logic              w_accept;
    logic              w_emif_acc;
    logic              w_is_first;
    logic              w_is_last;
    logic [BE_W-1:0]   w_mask;

    // Word count covers the start offset plus the byte count, rounded up;
    // summed in 33 bits so a near-4 GiB count cannot overflow.
    assign w_span  = 33'(ddr3_usr_start_addr_in[OFF_W-1:0]) + 33'(to_write_byte_in);
    assign w_words = CNT_W'((w_span + 33'd31) >> OFF_W);

    // The output register can take a new word when empty or being drained.
    assign w_slot     = ~r_wr | ddr3_emif_ready;
    assign w_emif_acc = r_wr & ddr3_emif_ready;
    assign write_data_ready_out = (r_state == ST_RUN) && (r_taken < r_words) && w_slot;
    assign w_accept   = write_data_valid_in & write_data_ready_out;

    assign w_is_first = (r_taken == '0);
    assign w_is_last  = (r_taken == r_words - CNT_W'(1));

    ddr3_be_gen u_be_gen (
        .i_first_off (r_off),
        .i_last_end  (r_end),
        .i_is_first  (w_is_first),
        .i_is_last   (w_is_last),
        .o_mask      (w_mask)
    );

    // Command FSM: latches the command, counts accepted input words and
    // produces registered busy/done flags.
    // NOTE: all state updates use <= so every register sees pre-edge values.
    always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
        if (!ddr3_emif_rst_n) begin
            r_state <= ST_IDLE;
            r_off   <= '0;
            r_end   <= '0;
            r_base  <= '0;
            r_words <= '0;
            r_taken <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ddr3_write_start) begin
                        r_off   <= ddr3_usr_start_addr_in[OFF_W-1:0];
                        r_base  <= ddr3_usr_start_addr_in[BYTE_ADDR_W-1:OFF_W];
                        r_end   <= w_span[OFF_W-1:0];
                        r_words <= w_words;
                        r_taken <= '0;
                        r_busy  <= 1'b1;
                        if (to_write_byte_in == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept)
                        r_taken <= r_taken + CNT_W'(1);
                    if (w_emif_acc && r_wr_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Avalon write register: loads on input accept, holds while the EMIF
    // stalls, and drops write once the final word has been taken.
    // NOTE: the wide data register is reset too, because every output must
    // read 0 while reset is asserted.
    always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
        if (!ddr3_emif_rst_n) begin
            r_wr      <= 1'b0;
            r_wr_last <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_be      <= '0;
        end else if (w_accept) begin
            r_wr      <= 1'b1;
            r_wr_last <= w_is_last;
            r_addr    <= r_base + r_taken[ADDR_W-1:0];
            r_data    <= write_data_in;
            r_be      <= w_mask;
        end else if (w_emif_acc) begin
            r_wr <= 1'b0;
        end
    end

    assign ddr3_emif_write       = r_wr;
    assign ddr3_emif_read        = 1'b0;
    assign ddr3_emif_addr        = r_addr;
    assign ddr3_emif_write_data  = r_data;
    assign ddr3_emif_byte_enable = r_be;
    assign ddr3_emif_burst_count = 5'd1;
    assign ddr3_write_busy_out   = r_busy;
    assign ddr3_write_done_out   = r_done;

endmodule

// File: tb/tb_ddr3_usr_write_logic.sv
// Scoreboard bench for ddr3_usr_write_logic: each command pushes the
// expected EMIF writes (byte-range model), the monitor pops on acceptance.
module tb_ddr3_usr_write_logic;
    import ddr3_usr_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   emif_ready = 1'b1;
    logic                   emif_write;
    logic                   emif_read;
    logic [ADDR_W-1:0]      emif_addr;
    logic [DATA_W-1:0]      emif_data;
    logic [BE_W-1:0]        emif_be;
    logic [4:0]             emif_burst;
    logic [BYTE_ADDR_W-1:0] start_addr = '0;
    logic [31:0]            nbytes = '0;
    logic                   start = 1'b0;
    logic                   busy;
    logic                   done;
    logic [DATA_W-1:0]      wdata = '0;
    logic                   wvalid = 1'b0;
    logic                   wready;

    ddr3_usr_write_logic dut (
        .ddr3_emif_clk          (clk),
        .ddr3_emif_rst_n        (rst_n),
        .ddr3_emif_ready        (emif_ready),
        .ddr3_emif_write        (emif_write),
        .ddr3_emif_read         (emif_read),
        .ddr3_emif_addr         (emif_addr),
        .ddr3_emif_write_data   (emif_data),
        .ddr3_emif_byte_enable  (emif_be),
        .ddr3_emif_burst_count  (emif_burst),
        .ddr3_usr_start_addr_in (start_addr),
        .to_write_byte_in       (nbytes),
        .ddr3_write_start       (start),
        .ddr3_write_busy_out    (busy),
        .ddr3_write_done_out    (done),
        .write_data_in          (wdata),
        .write_data_valid_in    (wvalid),
        .write_data_ready_out   (wready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_t;

    wr_t               sb[$];
    logic [DATA_W-1:0] src[$];
    int                n_chk = 0;
    int                n_bad = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++)
            w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write"}, 256'(emif_write), 256'(0));
        check({tag, "_read"},  256'(emif_read),  256'(0));
        check({tag, "_addr"},  256'(emif_addr),  256'(0));
        check({tag, "_data"},  emif_data,        256'(0));
        check({tag, "_be"},    256'(emif_be),    256'(0));
        check({tag, "_burst"}, 256'(emif_burst), 256'(1));
        check({tag, "_busy"},  256'(busy),       256'(0));
        check({tag, "_done"},  256'(done),       256'(0));
        check({tag, "_wrdy"},  256'(wready),     256'(0));
    endtask

    // Runs one command. bp_k/bp_len stall the EMIF on write index bp_k,
    // ign pulses a stray start mid-command, abort_at asserts reset at that
    // loop iteration (negative = never).
    task automatic run_cmd(input logic [BYTE_ADDR_W-1:0] a, input logic [31:0] n,
                           input int bp_k, input int bp_len, input bit ign, input int abort_at);
        longint unsigned la, ln, o, nw;
        int  wr_cnt  = 0;
        int  bp_left = bp_len;
        int  exp_done = -1;
        int  st_cyc;
        bit  seen = 1'b0;
        bit  in_acc;

        la = longint'(a);
        ln = longint'(n);
        o  = la % 32;
        nw = (o + ln + 31) / 32;
        for (longint unsigned k = 0; k < nw; k++) begin
            wr_t             e;
            longint unsigned wa;
            wa = la / 32 + k;
            for (int i = 0; i < BE_W; i++) begin
                longint unsigned ba;
                ba = wa * 32 + longint'(i);
                e.be[i] = (ba >= la) && (ba < la + ln);
            end
            e.addr = wa[ADDR_W-1:0];
            e.data = rand_word();
            sb.push_back(e);
            src.push_back(e.data);
        end
        src.push_back(rand_word());

        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        nbytes     = n;
        wvalid     = 1'b0;
        emif_ready = 1'b1;
        @(negedge clk);
        st_cyc = cyc;
        check("busy_at_start", 256'(busy), 256'(0));
        if (n == 0)
            exp_done = st_cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int i = 0; i < 200 && !seen; i++) begin
            start = ign && (i == 2);
            if (start) begin
                start_addr = 27'h1234567;
                nbytes     = 32'd99;
            end
            wvalid     = (src.size() > 0);
            wdata      = (src.size() > 0) ? src[0] : '0;
            emif_ready = !(wr_cnt == bp_k && bp_left > 0);
            @(negedge clk);
            if (done) begin
                check("done_cycle", 256'(cyc), 256'(exp_done));
                check("busy_at_done", 256'(busy), 256'(1));
                seen = 1'b1;
            end
            if (emif_write) begin
                if (sb.size() == 0) begin
                    check("spurious_write", 256'(1), 256'(0));
                end else begin
                    check("addr", 256'(emif_addr), 256'(sb[0].addr));
                    check("data", emif_data, sb[0].data);
                    check("be", 256'(emif_be), 256'(sb[0].be));
                    if (!emif_ready) begin
                        check("wrdy_stall", 256'(wready), 256'(0));
                        bp_left--;
                    end else begin
                        void'(sb.pop_front());
                        wr_cnt++;
                        if (sb.size() == 0)
                            exp_done = cyc + 1;
                    end
                end
            end
            in_acc = wvalid && wready;
            if (abort_at == i) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("midrun_rst");
                sb.delete();
                src.delete();
                start  = 1'b0;
                wvalid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            if (in_acc && src.size() > 0)
                void'(src.pop_front());
            #1;
        end
        start  = 1'b0;
        wvalid = 1'b0;
        emif_ready = 1'b1;
        if (!seen)
            check("done_timeout", 256'(0), 256'(1));
        check("sb_drained", 256'(sb.size()), 256'(0));
        check("extra_word_kept", 256'(src.size()), 256'(1));
        sb.delete();
        src.delete();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        run_cmd(27'h40,      32'd64,  -1, 0, 1'b0, -1);  // aligned, two full words
        run_cmd(27'h23,      32'd40,  -1, 0, 1'b0, -1);  // unaligned head and tail
        run_cmd(27'h105,     32'd4,   -1, 0, 1'b0, -1);  // single partial word
        run_cmd(27'h200,     32'd128,  1, 5, 1'b1, -1);  // stall on word 2 of 4, stray start
        run_cmd(27'h0,       32'd0,   -1, 0, 1'b0, -1);  // empty command
        run_cmd(27'h7FFFFE0, 32'd64,  -1, 0, 1'b0, -1);  // address wrap
        run_cmd(27'h300,     32'd128, -1, 0, 1'b0,  3);  // reset mid-run
        run_cmd(27'h1F,      32'd70,   2, 3, 1'b0, -1);  // recovery after reset

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr3_usr_write_logic.md
Name: ddr3_usr_write_logic

Overview:
Write-side counterpart of the DDR3 read path: takes a byte-range write command (byte start address, byte count) plus a stream of 256-bit lane-aligned data words. Issues single-beat Avalon-MM writes to the DDR3 EMIF. Generates 32-bit byte enables so unaligned first/last words only touch the addressed bytes. Sits between the frame-capture datapath and the DDR3 EMIF, sharing its clock.

Parameters:
DATA_W, 256, EMIF data width (bits)
BE_W, 32, byte-enable width = DATA_W/8
ADDR_W, 22, EMIF word address width
BYTE_ADDR_W, 27, user byte address width = ADDR_W + log2(BE_W)

Ports:
ddr3_emif_clk  in  1  sole clock
ddr3_emif_rst_n  in  1  reset; asynchronous, active-low
ddr3_emif_ready  in  1  EMIF accepts current command when high at clock edge
ddr3_emif_write  out  1  write request, held until accepted
ddr3_emif_read  out  1  constant 0
ddr3_emif_addr  out  ADDR_W  word address
ddr3_emif_write_data  out  DATA_W  write data
ddr3_emif_byte_enable  out  BE_W  bit i enables data[8i+7:8i]
ddr3_emif_burst_count  out  5  constant 1
ddr3_usr_start_addr_in  in  BYTE_ADDR_W  byte start address, sampled on start
to_write_byte_in  in  32  byte count N, sampled on start
ddr3_write_start  in  1  one-cycle command pulse
ddr3_write_busy_out  out  1  high from start accept until done
ddr3_write_done_out  out  1  one-cycle completion pulse
write_data_in  in  DATA_W  data word; byte lane i lands at DDR lane i
write_data_valid_in  in  1  source has a word
write_data_ready_out  out  1  block accepts word this cycle

Behaviour:
- Reset (async, any time, incl. mid-command): all outputs 0 except burst_count=1; state IDLE. An in-flight write is dropped.
- Latched on start in IDLE: o=addr[4:0]; W=addr[26:5]; words = (o+N+31)>>5, computed in 33 bits into a 28-bit counter; e=(o+N)[4:0]. Start while busy is ignored.
- States: IDLE -> (start, N!=0) RUN; IDLE -> (start, N==0) DONE; RUN -> DONE when the last word is accepted by the EMIF; DONE -> IDLE after one cycle with done_out=1.
- busy_out=1 in RUN and DONE.
- write_data_ready_out = (state==RUN) & (words_taken < words) & (~ddr3_emif_write | ddr3_emif_ready). This has a combinational path from ddr3_emif_ready.
- Accept (valid&ready) registers the word: ddr3_emif_write=1 next cycle, with addr = W + index (mod 2^22, wraps 0x3FFFFF -> 0x000000), data = write_data_in, byte_enable = mask.
- Throughput: 1 word/cycle when ready stays high. Latency: input accept to write asserted = 1 cycle.
- mask for word index k: first = ~0<<o when k==0, else all-ones; last = (e==0 ? all-ones : (1<<e)-1) when k==words-1, else all-ones; mask = first & last (a single word uses both).
- Avalon rule: while write=1 & ready=0, addr/data/byte_enable/write are held stable. write deasserts the cycle after the final acceptance unless a new word was accepted.
- done_out pulses exactly 1 cycle, the cycle after the last EMIF acceptance (or the cycle after start when N==0).
- Extra input words beyond `words` are never accepted (ready stays 0).

Decomposition:
- Package ddr3_usr_pkg: DATA_W/BE_W/ADDR_W constants, state encoding (IDLE, RUN, DONE), first/last mask functions.
- One sub-module, ddr3_be_gen: combinational first/last mask from (o, e, is_first, is_last). It is reusable by the read path.

Test Plan:
- Aligned: start 0x40, N=64, ready=1 -> 2 writes at addr 0x2, 0x3, be 0xFFFFFFFF each; done 1 cycle after 2nd accept.
- Unaligned: start 0x23, N=40 -> writes at 0x1 be 0xFFFFFFF8, then 0x2 be 0x000007FF.
- Single partial: start 0x105, N=4 -> one write at 0x8, be 0x000001E0.
- Backpressure: ready low 5 cycles on word 2 of 4 -> write/addr/data/be stable; write_data_ready_out=0; all 4 words written in order, none lost or duplicated.
- Edge: N=0 -> no write, done pulse next cycle. Start 0x7FFFFE0, N=64 -> addrs 0x3FFFFF then 0x000000.
- Reset asserted mid-RUN -> all outputs 0 immediately; a new command after release completes normally.
